// File: rtl/retire_monitor.sv
// Retirement monitor for the xgriscv write-back PC stream.
// Watches retired PCs for a halt address, flags a hang when PC progress
// stops for HANG_LIMIT consecutive RUN cycles, counts RUN cycles and
// retirements (saturating), and keeps a ring of the most recent retired PCs.
module retire_monitor #(
    parameter logic [31:0] HALT_PC     = 32'h000000ff,
    parameter int          HANG_LIMIT  = 16,
    parameter int          TRACE_DEPTH = 8,
    parameter int          CNT_W       = 32
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clr,
    input  logic                           pc_valid,
    input  logic [31:0]                    pc_w,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [31:0]                    trace_pc,
    output logic [1:0]                     state,
    output logic                           halted,
    output logic                           hung,
    output logic [31:0]                    last_pc,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [CNT_W-1:0]               retire_cnt
);

    localparam int               IDX_W    = $clog2(TRACE_DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [15:0]      HANG_LIM = 16'(HANG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10,
        ST_HUNG   = 2'b11
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             halted_r;
    logic             hung_r;
    logic [31:0]      last_pc_r;
    logic [CNT_W-1:0] cycle_r;
    logic [CNT_W-1:0] cycle_nxt_s;
    logic [CNT_W-1:0] retire_r;
    logic [15:0]      np_r;
    logic [15:0]      np_nxt_s;
    logic [15:0]      np_inc_s;
    logic             accept_s;
    logic [IDX_W-1:0] wr_ptr_r;
    logic [IDX_W-1:0] rd_ptr_s;
    logic [31:0]      trace_mem_r [TRACE_DEPTH];

    // Next-state, no-progress tracking and accept decision.
    always_comb begin
        state_nxt_s = state_r;
        np_nxt_s    = np_r;
        cycle_nxt_s = cycle_r;
        accept_s    = 1'b0;
        np_inc_s    = np_r + 16'd1;
        case (state_r)
            ST_IDLE: begin
                np_nxt_s = 16'd0;
                if (pc_valid) begin
                    accept_s    = 1'b1;
                    cycle_nxt_s = CNT_ONE;
                    state_nxt_s = (pc_w == HALT_PC) ? ST_HALTED : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                cycle_nxt_s = sat_inc(cycle_r);
                accept_s    = pc_valid;
                if (pc_valid && (pc_w == HALT_PC)) begin
                    // Halt wins over a hang that would trigger on the same edge.
                    state_nxt_s = ST_HALTED;
                end else if (pc_valid && (pc_w != last_pc_r)) begin
                    np_nxt_s    = 16'd0;
                    state_nxt_s = ST_RUN;
                end else begin
                    // Covers both an idle cycle and a self-loop retirement.
                    np_nxt_s = np_inc_s;
                    if (np_inc_s == HANG_LIM) begin
                        state_nxt_s = ST_HUNG;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_HALTED, ST_HUNG: begin
                state_nxt_s = state_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, status flags, counters and trace ring; reset and clr share one path.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state_r   <= ST_IDLE;
            halted_r  <= 1'b0;
            hung_r    <= 1'b0;
            last_pc_r <= 32'h0;
            cycle_r   <= '0;
            retire_r  <= '0;
            np_r      <= 16'd0;
            wr_ptr_r  <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_mem_r[i] <= 32'h0;
            end
        end else begin
            state_r  <= state_nxt_s;
            halted_r <= (state_nxt_s == ST_HALTED);
            hung_r   <= (state_nxt_s == ST_HUNG);
            cycle_r  <= cycle_nxt_s;
            np_r     <= np_nxt_s;
            if (accept_s) begin
                retire_r              <= sat_inc(retire_r);
                last_pc_r             <= pc_w;
                trace_mem_r[wr_ptr_r] <= pc_w;
                wr_ptr_r              <= wr_ptr_r + IDX_ONE;
            end
        end
    end

    // Index 0 is the newest entry; pointer arithmetic wraps with the ring size.
    assign rd_ptr_s   = wr_ptr_r - IDX_ONE - trace_idx;
    assign trace_pc   = trace_mem_r[rd_ptr_s];
    assign state      = state_r;
    assign halted     = halted_r;
    assign hung       = hung_r;
    assign last_pc    = last_pc_r;
    assign cycle_cnt  = cycle_r;
    assign retire_cnt = retire_r;

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor: a default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation scenario.
module tb_retire_monitor;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        pc_valid;
    logic [31:0] pc_w;
    logic [2:0]  trace_idx;
    logic [31:0] trace_pc;
    logic [1:0]  state;
    logic        halted;
    logic        hung;
    logic [31:0] last_pc;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    logic [31:0] trace_pc4;
    logic [1:0]  state4;
    logic        halted4;
    logic        hung4;
    logic [31:0] last_pc4;
    logic [3:0]  cycle_cnt4;
    logic [3:0]  retire_cnt4;

    int checks = 0;
    int errors = 0;

    retire_monitor dut (
        .clk(clk), .rstn(rstn), .clr(clr), .pc_valid(pc_valid), .pc_w(pc_w),
        .trace_idx(trace_idx), .trace_pc(trace_pc), .state(state),
        .halted(halted), .hung(hung), .last_pc(last_pc),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    retire_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .clr(clr), .pc_valid(pc_valid), .pc_w(pc_w),
        .trace_idx(trace_idx), .trace_pc(trace_pc4), .state(state4),
        .halted(halted4), .hung(hung4), .last_pc(last_pc4),
        .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; clr = 1'b0; pc_valid = 1'b0; pc_w = 32'h0; trace_idx = 3'd0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic run_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            pc_valid = 1'b1;
            pc_w = base + 32'(4 * i);
            tick();
        end
        pc_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        pc_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0h exp 0", state); end
        checks++; if (halted !== 1'b0 || hung !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", halted, hung); end
        checks++; if (last_pc !== 32'h0) begin errors++; $display("FAIL reset_last_pc got %h exp 0", last_pc); end
        checks++; if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", cycle_cnt, retire_cnt); end
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
            checks++; if (trace_pc !== 32'h0) begin errors++; $display("FAIL reset_trace idx %0d got %h exp 0", i, trace_pc); end
        end
        trace_idx = 3'd0;
        // Idle cycles after reset must not count.
        idle_cycles(3);
        checks++; if (state !== 2'b00 || cycle_cnt !== 32'd0) begin errors++; $display("FAIL idle_hold got st %0h cyc %0d exp 0/0", state, cycle_cnt); end
    endtask

    task automatic test_basic_run();
        do_reset();
        run_stream(32'h0, 9);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL basic_state got %0h exp 1", state); end
        checks++; if (retire_cnt !== 32'd9) begin errors++; $display("FAIL basic_retire got %0d exp 9", retire_cnt); end
        checks++; if (cycle_cnt !== 32'd9) begin errors++; $display("FAIL basic_cycle got %0d exp 9", cycle_cnt); end
        checks++; if (last_pc !== 32'h20) begin errors++; $display("FAIL basic_last_pc got %h exp 20", last_pc); end
        trace_idx = 3'd0; #1;
        checks++; if (trace_pc !== 32'h20) begin errors++; $display("FAIL basic_trace0 got %h exp 20", trace_pc); end
        trace_idx = 3'd1; #1;
        checks++; if (trace_pc !== 32'h1c) begin errors++; $display("FAIL basic_trace1 got %h exp 1c", trace_pc); end
        trace_idx = 3'd7; #1;
        checks++; if (trace_pc !== 32'h04) begin errors++; $display("FAIL basic_trace7 got %h exp 04", trace_pc); end
        trace_idx = 3'd0;
        // RUN keeps counting cycles without retirements.
        idle_cycles(2);
        checks++; if (cycle_cnt !== 32'd11 || retire_cnt !== 32'd9) begin errors++; $display("FAIL basic_idle_cnt got %0d/%0d exp 11/9", cycle_cnt, retire_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        run_stream(32'h0, 64);
        checks++; if (halted !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL halt_pre got h %b st %0h exp 0/1", halted, state); end
        pc_valid = 1'b1; pc_w = 32'hff;
        tick();
        pc_valid = 1'b0;
        checks++; if (halted !== 1'b1 || state !== 2'b10 || hung !== 1'b0) begin errors++; $display("FAIL halt_flag got h %b st %0h hung %b exp 1/2/0", halted, state, hung); end
        checks++; if (retire_cnt !== 32'd65) begin errors++; $display("FAIL halt_retire got %0d exp 65", retire_cnt); end
        trace_idx = 3'd0; #1;
        checks++; if (trace_pc !== 32'hff) begin errors++; $display("FAIL halt_trace0 got %h exp ff", trace_pc); end
        run_stream(32'h300, 3);
        checks++; if (retire_cnt !== 32'd65 || cycle_cnt !== 32'd65) begin errors++; $display("FAIL halt_frozen_cnt got %0d/%0d exp 65/65", retire_cnt, cycle_cnt); end
        checks++; if (last_pc !== 32'hff || trace_pc !== 32'hff || state !== 2'b10) begin errors++; $display("FAIL halt_frozen got lp %h tr %h st %0h exp ff/ff/2", last_pc, trace_pc, state); end
    endtask

    task automatic test_hang_self_loop();
        do_reset();
        run_stream(32'h0, 5);
        pc_valid = 1'b1; pc_w = 32'h10;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (hung !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL loop_pre got hung %b st %0h exp 0/1", hung, state); end
        tick();
        pc_valid = 1'b0;
        checks++; if (hung !== 1'b1 || state !== 2'b11 || halted !== 1'b0) begin errors++; $display("FAIL loop_hung got hung %b st %0h exp 1/3", hung, state); end
        checks++; if (retire_cnt !== 32'd21) begin errors++; $display("FAIL loop_retire got %0d exp 21", retire_cnt); end
        run_stream(32'h500, 2);
        checks++; if (retire_cnt !== 32'd21 || state !== 2'b11) begin errors++; $display("FAIL loop_sticky got %0d st %0h exp 21/3", retire_cnt, state); end
    endtask

    task automatic test_hang_gap();
        do_reset();
        run_stream(32'h0, 5);
        idle_cycles(15);
        checks++; if (state !== 2'b01 || hung !== 1'b0) begin errors++; $display("FAIL gap_pre got st %0h exp 1", state); end
        run_stream(32'h14, 1);
        checks++; if (state !== 2'b01 || last_pc !== 32'h14) begin errors++; $display("FAIL gap_progress got st %0h lp %h exp 1/14", state, last_pc); end
        idle_cycles(15);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL gap_cleared got st %0h exp 1", state); end
        idle_cycles(1);
        checks++; if (state !== 2'b11 || hung !== 1'b1) begin errors++; $display("FAIL gap_hung got st %0h hung %b exp 3/1", state, hung); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run_stream(32'h0, 5);
        idle_cycles(15);
        run_stream(32'hff, 1);
        checks++; if (state !== 2'b10 || halted !== 1'b1 || hung !== 1'b0) begin errors++; $display("FAIL simul_halt got st %0h h %b hung %b exp 2/1/0", state, halted, hung); end
        // clr together with pc_valid drops the sample.
        do_reset();
        run_stream(32'h0, 3);
        clr = 1'b1; pc_valid = 1'b1; pc_w = 32'h40;
        tick();
        clr = 1'b0; pc_valid = 1'b0;
        checks++; if (state !== 2'b00 || retire_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin errors++; $display("FAIL clr_cnts got st %0h r %0d c %0d exp 0/0/0", state, retire_cnt, cycle_cnt); end
        trace_idx = 3'd0; #1;
        checks++; if (last_pc !== 32'h0 || trace_pc !== 32'h0) begin errors++; $display("FAIL clr_data got lp %h tr %h exp 0/0", last_pc, trace_pc); end
    endtask

    task automatic test_trace_wrap();
        do_reset();
        run_stream(32'h100, 11);
        trace_idx = 3'd0; #1;
        checks++; if (trace_pc !== 32'h128) begin errors++; $display("FAIL wrap_idx0 got %h exp 128", trace_pc); end
        trace_idx = 3'd3; #1;
        checks++; if (trace_pc !== 32'h11c) begin errors++; $display("FAIL wrap_idx3 got %h exp 11c", trace_pc); end
        trace_idx = 3'd7; #1;
        checks++; if (trace_pc !== 32'h10c) begin errors++; $display("FAIL wrap_idx7 got %h exp 10c", trace_pc); end
        trace_idx = 3'd0;
    endtask

    task automatic test_saturation();
        do_reset();
        run_stream(32'h200, 20);
        checks++; if (cycle_cnt4 !== 4'hf || retire_cnt4 !== 4'hf) begin errors++; $display("FAIL sat_cnt4 got %h/%h exp f/f", cycle_cnt4, retire_cnt4); end
        checks++; if (cycle_cnt !== 32'd20 || retire_cnt !== 32'd20) begin errors++; $display("FAIL sat_cnt32 got %0d/%0d exp 20/20", cycle_cnt, retire_cnt); end
        rstn = 1'b0;
        tick();
        checks++; if (state !== 2'b00 || halted !== 1'b0 || hung !== 1'b0 || last_pc !== 32'h0) begin errors++; $display("FAIL midrst_state got st %0h lp %h exp 0/0", state, last_pc); end
        checks++; if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0 || cycle_cnt4 !== 4'h0 || retire_cnt4 !== 4'h0) begin errors++; $display("FAIL midrst_cnts got %0d/%0d/%h/%h exp 0", cycle_cnt, retire_cnt, cycle_cnt4, retire_cnt4); end
        trace_idx = 3'd0; #1;
        checks++; if (trace_pc !== 32'h0) begin errors++; $display("FAIL midrst_trace got %h exp 0", trace_pc); end
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_halt();
        test_hang_self_loop();
        test_hang_gap();
        test_simultaneous();
        test_trace_wrap();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_monitor.md
Name: retire_monitor

Overview:
- Synthesizable retirement monitor that sits directly downstream of the single-cycle xgriscv core and consumes its write-back PC stream (pcW).
- Detects program completion, when the retired PC equals a configured halt address.
- Detects hangs, when PC progress stops for too long.
- Counts cycles and retired instructions, and keeps a small ring buffer of the most recent retired PCs for on-board debug and for bench end-of-test checks.

Parameters:
- HALT_PC, 32'h000000ff: retired-PC value that signals program completion.
- HANG_LIMIT, 16: consecutive no-progress RUN cycles that declare a hang; legal range 2..65535.
- TRACE_DEPTH, 8: trace ring entries; must be a power of 2, at least 2.
- CNT_W, 32: width of cycle_cnt and retire_cnt.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- clr  in  1  synchronous clear; same effect as reset.
- pc_valid  in  1  an instruction retires this cycle.
- pc_w  in  32  PC of the retiring instruction; qualified by pc_valid.
- trace_idx  in  log2(TRACE_DEPTH)  trace read index; 0 = most recent.
- trace_pc  out  32  trace entry selected by trace_idx; combinational read.
- state  out  2  IDLE=00, RUN=01, HALTED=10, HUNG=11.
- halted  out  1  high iff state==HALTED.
- hung  out  1  high iff state==HUNG.
- last_pc  out  32  most recently retired PC.
- cycle_cnt  out  CNT_W  cycles spent in RUN, including the entry cycle.
- retire_cnt  out  CNT_W  retirements accepted.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rstn, sampled on the rising edge of clk.
- Reset values (rstn==0 or clr==1 at a clock edge): state=IDLE; halted=0; hung=0; last_pc=0; cycle_cnt=0; retire_cnt=0; no-progress counter=0; trace write pointer=0; all trace entries=0.
- Precedence: rstn over clr; clr over every other event. A pc_valid in a clearing cycle is dropped.
- "Accept" a retirement means all of the following in the same edge: retire_cnt+1, last_pc<=pc_w, pc_w written at the write pointer, write pointer +1 modulo TRACE_DEPTH.

IDLE:
- cycle_cnt does not count.
- On pc_valid: accept; set cycle_cnt=1.
- If pc_w==HALT_PC, go to HALTED; otherwise go to RUN.

RUN:
- Every cycle: cycle_cnt+1.
- On pc_valid: accept.
- If pc_valid and pc_w==HALT_PC, go to HALTED. This has priority over the hang check in the same cycle.
- No-progress counter:
  - Clears to 0 on pc_valid with pc_w != last_pc.
  - Otherwise increments, covering both no pc_valid and a self-loop with pc_w==last_pc.
  - When the incremented value equals HANG_LIMIT, go to HUNG on that edge.

HALTED / HUNG:
- Sticky until reset or clr.
- No counting, no accepts, trace frozen.
- trace_pc stays readable.

Counters:
- cycle_cnt and retire_cnt saturate at all-ones and never wrap.

Latency:
- halted and hung are registered. They assert on the edge that samples the triggering pc_valid, i.e. visible in the cycle after the halting retirement or after the HANG_LIMIT-th no-progress cycle.

Trace:
- trace_pc = entry at (write pointer - 1 - trace_idx) modulo TRACE_DEPTH.
- Entries never written read 0.
- The write pointer wraps silently; the oldest entry is overwritten.

Test Plan:
- Reset then basic run: rstn low 2 cycles, then pc_valid every cycle with pc_w = 0,4,8,...,0x20 (9 retirements) -> state=RUN, retire_cnt=9, cycle_cnt=9, last_pc=0x20, trace_pc at idx 0/1/7 = 0x20/0x1c/0x04.
- Halt detection: stream 0,4,...,0xfc, then 0xff -> halted=1 the cycle after 0xff is sampled, retire_cnt=65, trace idx0=0xff; later pc_valid pulses leave all counters unchanged.
- Hang via self-loop and via gaps: after reaching 0x10, hold pc_valid=1 with pc_w=0x10 -> hung=1 after exactly 16 edges. Repeat with pc_valid=0 for 15 cycles then pc_w=0x14 -> state stays RUN and the no-progress counter clears.
- Simultaneous events: pc_w=HALT_PC in the same cycle the no-progress counter would reach HANG_LIMIT -> state=HALTED, hung=0. Also, clr=1 together with pc_valid -> everything zero, state=IDLE, sample dropped.
- Trace wrap: 11 retirements 0x100..0x128 with TRACE_DEPTH=8 -> idx0=0x128, idx7=0x10c; before any retirement after reset, all indices read 0.
- Saturation and reset mid-run: CNT_W=4, run 20 cycles -> cycle_cnt=4'hf held. Then rstn=0 for one edge during RUN -> all outputs return to reset values on that edge.
